// File: rtl/cpu_wb.sv
// rtl/cpu_wb.sv - MEM/WB pipeline register, register-file write port and retirement tracking.
module cpu_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        validM,
  input  logic [1:0]  WBcontrolsM,
  input  logic [15:0] aluOutM,
  input  logic [15:0] memDataM,
  input  logic [3:0]  dstRegM,
  input  logic        haltM,
  output logic [15:0] wrData,
  output logic        regWrite,
  output logic [3:0]  wrReg,
  output logic        validW,
  output logic        halted,
  output logic [15:0] retireCount
);

  logic        validR;
  logic        memToRegR;
  logic        regWriteR;
  logic [15:0] aluOutR;
  logic [15:0] memDataR;
  logic [3:0]  dstRegR;
  logic        haltR;

  logic retire;
  logic haltRetire;

  assign retire     = validR & ~stall & ~halted;
  assign haltRetire = retire & haltR;

  always_ff @(posedge clk) begin
    if (rst) begin
      validR      <= 1'b0;
      memToRegR   <= 1'b0;
      regWriteR   <= 1'b0;
      aluOutR     <= 16'h0000;
      memDataR    <= 16'h0000;
      dstRegR     <= 4'h0;
      haltR       <= 1'b0;
      halted      <= 1'b0;
      retireCount <= 16'h0000;
    end else begin
      if (retire) begin
        retireCount <= retireCount + 16'h0001;
      end
      if (haltRetire) begin
        halted <= 1'b1;
      end

      // The HLT's successor is dropped on the retiring edge so nothing enters WB once halted.
      if (halted || haltRetire || flush) begin
        validR    <= 1'b0;
        regWriteR <= 1'b0;
        haltR     <= 1'b0;
      end else if (!stall) begin
        validR    <= validM;
        memToRegR <= WBcontrolsM[1];
        regWriteR <= WBcontrolsM[0];
        aluOutR   <= aluOutM;
        memDataR  <= memDataM;
        dstRegR   <= dstRegM;
        haltR     <= haltM;
      end
    end
  end

  assign wrData   = memToRegR ? memDataR : aluOutR;
  assign wrReg    = dstRegR;
  assign validW   = validR;
  assign regWrite = validR & regWriteR & (dstRegR != 4'h0) & ~halted;

endmodule

// File: doc/cpu_wb.md
CPU_WB -- requirements
Module: cpu_wb

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 stall  in  1  hold MEM/WB register contents.
REQ-004 flush  in  1  load a bubble into MEM/WB register.
REQ-005 validM  in  1  MEM-stage slot holds a real instruction.
REQ-006 WBcontrolsM  in  2  {memToReg, regWrite} bundle from decode, carried through EX/MEM.
REQ-007 aluOutM  in  16  ALU result from MEM stage.
REQ-008 memDataM  in  16  data-memory read result from MEM stage.
REQ-009 dstRegM  in  4  destination register index.
REQ-010 haltM  in  1  instruction is HLT.
REQ-011 wrData  out  16  register-file write data, drives decode wrData.
REQ-012 regWrite  out  1  register-file write enable, drives decode regWrite.
REQ-013 wrReg  out  4  register-file write index; also forwarding source index.
REQ-014 validW  out  1  WB slot holds a real instruction.
REQ-015 halted  out  1  sticky: HLT has retired.
REQ-016 retireCount  out  16  count of retired instructions.

Function
REQ-017 MEM/WB register fields SHALL be: valid, memToReg, regWrite, aluOut, memData, dstReg, halt.
- Update priority: rst > halted > flush > stall > load.
REQ-018 Load SHALL capture all M-inputs, so the WB outputs reflect them one cycle after presentation.
REQ-019 Flush SHALL clear valid, regWrite and halt. Data fields are don't-care.
REQ-020 Stall SHALL hold every field unchanged.
REQ-021 While halted=1, the register SHALL load a bubble every cycle, ignoring flush, stall and the M-inputs.
REQ-022 wrData SHALL be combinational from the register: memToReg ? memData : aluOut, full 16 bits, no extension.
REQ-023 wrReg SHALL equal registered dstReg.
REQ-024 validW SHALL equal registered valid.
REQ-025 regWrite SHALL be asserted only when all of the following hold:
- validW=1, registered regWrite=1, dstReg≠4'h0, halted=0.
- Writes to R0 are suppressed.
REQ-026 A retire event SHALL be defined as validW=1 & stall=0 & halted=0 at a rising edge.
- A stalled instruction retires exactly once, on the edge where stall=0.
REQ-027 Each retire event SHALL increment retireCount by 1, modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-028 A retire event with registered halt=1 SHALL set halted=1 on that edge and count the HLT itself.
REQ-029 halted SHALL stay 1 until rst; no further retire events, writes or counts occur.
REQ-030 flush and stall asserted together SHALL act as flush; the WB instruction still retires if stall=0.
- Flush affects only the incoming slot.
REQ-031 The block SHALL contain no combinational path from any M-input to any output.

Reset
REQ-032 On a rising edge with rst=1, all register fields SHALL clear to 0, halted=0 and retireCount=16'h0000.
REQ-033 The cycle after reset, the outputs SHALL be: validW=0, regWrite=0, wrReg=4'h0, wrData=16'h0000.
REQ-034 rst SHALL override stall, flush and halted in the same cycle.
- rst mid-stall or after halt returns to the REQ-033 state.

Verification
REQ-035 ALU path: validM=1, WBcontrolsM=2'b01, aluOutM=16'h1234, dstRegM=4'h5 for one cycle.
- Required next cycle: regWrite=1, wrReg=5, wrData=16'h1234.
- retireCount=1 after the following edge.
REQ-036 Load path: WBcontrolsM=2'b11, memDataM=16'hBEEF, aluOutM=16'h0002, dstRegM=4'hA.
- Required: wrData=16'hBEEF, regWrite=1.
REQ-037 R0 suppression: WBcontrolsM=2'b01, dstRegM=4'h0.
- Required: validW=1, regWrite=0; retireCount still increments.
REQ-038 Stall plus flush: with an instruction in WB, hold stall=1 for 3 cycles, then stall=0 with flush=1.
- Required: outputs held unchanged for 3 cycles.
- retireCount increments exactly once.
- Next cycle validW=0.
REQ-039 Halt: send HLT (haltM=1) followed by valid writes.
- Required: halted=1 after HLT retires and retireCount includes the HLT.
- Following instructions produce regWrite=0, validW=0, no further counts.
- rst then returns the REQ-033 state.
REQ-040 Wrap: preload retireCount to 16'hFFFF by retiring instructions, then retire one more.
- Required: retireCount=16'h0000.
